// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for eight requesters with binary grant index, grant
// enable and a hold limit that force-releases a grant after MAX_HOLD cycles.
module rr_grant_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam bit          HOLD_EN = (MAX_HOLD != 0);
  // Counter value on the last permitted grant cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_en_q, grant_en_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // First requester at or after ptr, scanning upward with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_idx_d = grant_idx_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          hold_d      = '0;
        end
      end
      GRANT: begin
        if (done || !req[grant_idx_q]) begin
          state_d = IDLE;
          ptr_d   = grant_idx_q + IDX_W'(1);
        end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
          state_d   = IDLE;
          ptr_d     = grant_idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    grant_en_d = (state_d == GRANT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Scoreboard bench for rr_grant_arbiter8: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them one step later.
module tb_rr_grant_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit en;
    int idx;
    bit to;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  bit m_busy;
  int m_owner;
  int m_len;
  int m_ptr;
  bit m_to;

  rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: predicts outputs visible after each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_len = 0; m_ptr = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (req[j]) begin
              m_owner = j;
              break;
            end
          end
          m_busy = 1;
          m_len  = 1;
        end
      end else begin
        if (done || !req[m_owner]) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 8;
        end else if (MAX_HOLD != 0 && m_len == MAX_HOLD) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 8;
          m_to   = 1;
        end else begin
          m_len = m_len + 1;
        end
      end
      exp_q.push_back('{en: m_busy, idx: m_owner, to: m_to});
    end
  end

  // Monitor: compares DUT outputs against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (grant_en !== e.en || int'(grant_idx) != e.idx || timeout !== e.to) begin
          errors++;
          $display("FAIL cycle_outputs at %0t: got en=%0b idx=%0d to=%0b expected en=%0b idx=%0d to=%0b",
                   $time, grant_en, grant_idx, timeout, e.en, e.idx, e.to);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (grant_en !== 1'b0 || grant_idx !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: got en=%0b idx=%0d to=%0b expected en=0 idx=0 to=0",
               name, grant_en, grant_idx, timeout);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for grant_en at a falling edge.
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (grant_en !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got grant_en=%0b expected 1 within 20 cycles", name, grant_en);
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    #12;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Single requester, done pulse, regrant
    req = 8'h20;
    cycles(3);
    done = 1'b1;
    cycles(1);
    done = 1'b0;
    cycles(4);
    req = 8'h00;
    cycles(2);

    // Full rotation with done held
    req = 8'hFF; done = 1'b1;
    cycles(20);
    req = 8'h00; done = 1'b0;
    cycles(2);

    // Skip and wrap
    req = 8'h09; done = 1'b1;
    cycles(8);
    req = 8'h00; done = 1'b0;
    cycles(2);

    // Forced release by hold limit
    req = 8'h0C;
    cycles(40);
    req = 8'h00;
    cycles(2);

    // done on the same edge the limit is reached
    req = 8'h04;
    wait_grant("limit_done");
    cycles(15);
    done = 1'b1;
    cycles(1);
    done = 1'b0; req = 8'h00;
    cycles(3);

    // Owner drops request mid-grant
    req = 8'h02;
    cycles(4);
    req = 8'h00;
    cycles(3);

    // done while idle has no effect
    done = 1'b1;
    cycles(3);
    done = 1'b0;
    req = 8'h10;
    cycles(3);

    // Reset mid-grant, then restart from ptr 0
    req = 8'hFF;
    wait_grant("mid_reset");
    cycles(1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_grant");
    @(negedge clk);
    rst = 1'b0;
    req = 8'h01;
    cycles(4);
    req = 8'h00;
    cycles(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      if ($urandom_range(0, 15) == 0) req = 8'h00;
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_random");
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    req = 8'h00; done = 1'b0;
    cycles(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
